// File: rtl/dense_tile_scheduler.sv
// dense_tile_scheduler: sequences one dense-layer evaluation over a shared
// multiply/reduce engine. Tiles of TILE input columns are issued whenever the
// engine is ready; each reduced sum returns REDUCE_LAT cycles later and is
// added into the accumulators. ap_done pulses once the last sum has landed.
module dense_tile_scheduler #(
  parameter int N_IN       = 64,
  parameter int TILE       = 16,
  parameter int REDUCE_LAT = 2,
  parameter int COL_W      = 7
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  input  logic             eng_ready,
  output logic             ap_ready,
  output logic             ap_idle,
  output logic             ap_done,
  output logic [COL_W-1:0] tile_col,
  output logic             issue_valid,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             result_valid
);

  localparam int CNT_W = $clog2(REDUCE_LAT + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_IN - TILE);
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(TILE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic                rv_q;
  logic [REDUCE_LAT-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;

  // Strobes decode the registered state; all of them are held low while
  // reset is asserted so a run caught mid-flight cannot leak a pulse.
  assign ap_ready     = ap_rst_n && (state_q == S_IDLE) && ap_start;
  assign acc_clear    = ap_ready;
  assign ap_idle      = (!ap_rst_n || (state_q == S_IDLE)) && !ap_start;
  assign issue_valid  = ap_rst_n && (state_q == S_ISSUE) && eng_ready;
  assign acc_en       = ap_rst_n && vld_q[REDUCE_LAT-1];
  assign ap_done      = ap_rst_n && (state_q == S_DONE);
  assign tile_col     = col_q;
  assign result_valid = rv_q;

  // Control FSM: start acceptance, tile walk, drain and completion.
  always_ff @(posedge ap_clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers see
    // the same pre-edge values regardless of statement order.
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            state_q <= S_ISSUE;
            col_q   <= '0;
            rv_q    <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (eng_ready) begin
            // The last tile leaves tile_col parked at its column, never wrapped.
            if (col_q == LAST_COL) state_q <= S_DRAIN;
            else                   col_q   <= col_q + COL_STEP;
          end
        end
        S_DRAIN: begin
          if (acc_en && (inflight_q == CNT_W'(1))) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          rv_q    <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Free-running valid delay line mirroring the engine's reduce latency;
  // eng_ready only gates new issues, never the returning sums.
  always_comb begin
    vld_d = REDUCE_LAT'({vld_q, issue_valid});
  end

  // Outstanding-tile count: issues add, returning sums retire.
  always_comb begin
    // NOTE: the default assignment up front keeps this block free of latches
    // on the paths where no case arm applies.
    inflight_d = inflight_q;
    case ({issue_valid, acc_en})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Pipeline tracking registers.
  always_ff @(posedge ap_clk) begin
    // NOTE: the delay line is reset, not left free, so sums from issues made
    // before a reset can never surface as acc_en afterwards.
    if (!ap_rst_n) begin
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_dense_tile_scheduler.sv
// Self-checking bench for dense_tile_scheduler: directed cycle-exact runs
// logged as per-cycle bit masks, then randomised engine back-pressure with a
// tile_col scoreboard and a latency prediction built from the driven eng_ready.
module tb_dense_tile_scheduler;

  localparam int N_IN  = 64;
  localparam int TILE  = 16;
  localparam int RL    = 2;
  localparam int COL_W = 7;
  localparam int NT    = N_IN / TILE;
  localparam int LAST  = N_IN - TILE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rdy   = 1'b0;

  logic             ap_ready, ap_idle, ap_done, issue_valid, acc_clear, acc_en, result_valid;
  logic [COL_W-1:0] tile_col;
  logic             s_ready, s_idle, s_done, s_issue, s_clear, s_acc, s_rv;
  logic [4:0]       s_col;

  dense_tile_scheduler #(.N_IN(N_IN), .TILE(TILE), .REDUCE_LAT(RL), .COL_W(COL_W)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start), .eng_ready(rdy),
    .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done), .tile_col(tile_col),
    .issue_valid(issue_valid), .acc_clear(acc_clear), .acc_en(acc_en),
    .result_valid(result_valid)
  );

  // Single-tile configuration with the shortest reduce latency.
  dense_tile_scheduler #(.N_IN(16), .TILE(16), .REDUCE_LAT(1), .COL_W(5)) dut_s (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start), .eng_ready(rdy),
    .ap_ready(s_ready), .ap_idle(s_idle), .ap_done(s_done), .tile_col(s_col),
    .issue_valid(s_issue), .acc_clear(s_clear), .acc_en(s_acc),
    .result_valid(s_rv)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Shared between driver (writer) and monitor (reader).
  int rel    = -1;
  bit mon_on = 1'b0;
  bit sb_on  = 1'b0;

  // Written only by the monitor.
  logic [31:0]      m_ready, m_clear, m_issue, m_acc, m_done, m_rv, m_idle;
  logic [31:0]      sm_ready, sm_clear, sm_issue, sm_acc, sm_done, sm_rv, sm_idle;
  logic [COL_W-1:0] col_log [32];
  logic [4:0]       s_col1;
  int               iss_cnt = 0;
  int               acc_cnt = 0;

  logic [COL_W-1:0] exp_col_q [$];

  // Monitor: samples on the falling edge, checks invariants, logs directed runs.
  always @(negedge clk) begin
    if (mon_on) begin
      check("col_bound", tile_col <= LAST, 1);
      check("clear_excl", acc_clear && (acc_en || issue_valid), 0);
      if (ap_ready) begin
        iss_cnt = 0;
        acc_cnt = 0;
      end
      if (issue_valid) iss_cnt++;
      if (acc_en) acc_cnt++;
      check("inflight_bound", (iss_cnt - acc_cnt) <= RL, 1);
      if (sb_on && issue_valid) begin
        check("sb_pending", exp_col_q.size() != 0, 1);
        if (exp_col_q.size() != 0) check("sb_col", tile_col, exp_col_q.pop_front());
      end
      if (rel >= 0 && rel < 32) begin
        if (rel == 0) begin
          m_ready = '0; m_clear = '0; m_issue = '0; m_acc = '0; m_done = '0; m_rv = '0; m_idle = '0;
          sm_ready = '0; sm_clear = '0; sm_issue = '0; sm_acc = '0; sm_done = '0; sm_rv = '0; sm_idle = '0;
        end
        m_ready[rel]  = ap_ready;  m_clear[rel] = acc_clear; m_issue[rel] = issue_valid;
        m_acc[rel]    = acc_en;    m_done[rel]  = ap_done;   m_rv[rel]    = result_valid;
        m_idle[rel]   = ap_idle;   col_log[rel] = tile_col;
        sm_ready[rel] = s_ready;   sm_clear[rel] = s_clear;  sm_issue[rel] = s_issue;
        sm_acc[rel]   = s_acc;     sm_done[rel]  = s_done;   sm_rv[rel]    = s_rv;
        sm_idle[rel]  = s_idle;
        if (rel == 1) s_col1 = s_col;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed run: start at relative cycle 0 (held if hold), eng_ready low in
  // cycles flagged in stall, reset low in cycle rst_at.
  task automatic run_seq(input logic [31:0] stall, input bit hold, input int rst_at, input int len);
    for (int c = 0; c < len; c++) begin
      rel   = c;
      start = (c == 0) || hold;
      rdy   = !stall[c];
      rst_n = (c != rst_at);
      step();
    end
    rel   = -1;
    start = 1'b0;
    rdy   = 1'b1;
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_b [7];
    exp_b = '{0, 0, 16, 16, 16, 32, 48};

    // Reset behaviour, with start both high and low while held in reset.
    step();
    step();
    start = 1'b1;
    #1;
    check("rst_ready", ap_ready, 0);
    check("rst_clear", acc_clear, 0);
    check("rst_issue", issue_valid, 0);
    check("rst_acc", acc_en, 0);
    check("rst_done", ap_done, 0);
    check("rst_idle_start1", ap_idle, 0);
    check("rst_col", tile_col, 0);
    check("rst_rv", result_valid, 0);
    start = 1'b0;
    #1;
    check("rst_idle_start0", ap_idle, 1);
    rst_n  = 1'b1;
    rdy    = 1'b1;
    mon_on = 1'b1;
    step();

    // Nominal run, engine always ready.
    run_seq(32'h0, 1'b0, -1, 12);
    check("A_ready", m_ready, 32'h1);
    check("A_clear", m_clear, 32'h1);
    check("A_issue", m_issue, 32'h1E);
    check("A_acc", m_acc, 32'h78);
    check("A_done", m_done, 32'h80);
    check("A_rv", m_rv & ~32'h1, 32'hF00);
    check("A_idle", m_idle, 32'hF00);
    for (int i = 1; i <= NT; i++) check("A_col", col_log[i], (i - 1) * TILE);
    check("E_ready", sm_ready, 32'h1);
    check("E_clear", sm_clear, 32'h1);
    check("E_issue", sm_issue, 32'h2);
    check("E_col", s_col1, 0);
    check("E_acc", sm_acc, 32'h4);
    check("E_done", sm_done, 32'h8);
    check("E_rv", sm_rv & ~32'h1, 32'hFF0);
    check("E_idle", sm_idle, 32'hFF0);

    // Engine stalls in cycles 2 and 3.
    run_seq(32'hC, 1'b0, -1, 12);
    check("B_issue", m_issue, 32'h72);
    check("B_acc", m_acc, 32'h1C8);
    check("B_done", m_done, 32'h200);
    check("B_rv", m_rv & ~32'h1, 32'hC00);
    for (int i = 1; i <= 6; i++) check("B_col", col_log[i], exp_b[i]);

    // ap_start held high: back-to-back runs, one acceptance each.
    run_seq(32'h0, 1'b1, -1, 24);
    check("C_ready", m_ready, 32'h10101);
    check("C_clear", m_clear, 32'h10101);
    check("C_issue", m_issue, 32'h1E1E1E);
    check("C_acc", m_acc, 32'h787878);
    check("C_done", m_done, 32'h808080);
    check("C_rv", m_rv & ~32'h1, 32'h10100);

    // Reset pulse in cycle 3 aborts the run.
    run_seq(32'h0, 1'b0, 3, 12);
    check("D_ready", m_ready, 32'h1);
    check("D_issue", m_issue, 32'h6);
    check("D_acc", m_acc, 32'h0);
    check("D_done", m_done, 32'h0);
    check("D_idle", m_idle, 32'hFF8);
    check("D_rv", m_rv & ~32'h1, 32'h0);
    check("D_col4", col_log[4], 0);

    // Randomised back-pressure with start noise while busy.
    sb_on = 1'b1;
    for (int r = 0; r < 1000; r++) begin
      int ready_seen = 0;
      int last_iss   = -1;
      int k          = 0;
      bit done_seen  = 1'b0;
      for (int j = 0; j < NT; j++) exp_col_q.push_back(COL_W'(j * TILE));
      start = 1'b1;
      rdy   = ($urandom_range(0, 1) == 1);
      step();
      k = 1;
      while (!done_seen && k < 200) begin
        rdy   = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        if (ready_seen < NT && rdy) begin
          ready_seen++;
          if (ready_seen == NT) last_iss = k;
        end
        #1;
        if (ap_done) begin
          done_seen = 1'b1;
          check("R_latency", k, last_iss + RL + 1);
          check("R_acc_count", acc_cnt, NT);
          check("R_sb_empty", exp_col_q.size(), 0);
          start = 1'b0;
        end
        step();
        k++;
      end
      if (!done_seen) begin
        check("R_timeout", done_seen, 1);
        exp_col_q.delete();
        start = 1'b0;
        break;
      end
    end
    sb_on = 1'b0;
    start = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dense_tile_scheduler.md
DENSE_TILE_SCHEDULER -- requirements
Module: dense_tile_scheduler

Interface
REQ-001 Parameter N_IN, default 64, input-vector length in elements; SHALL be an integer multiple of TILE.
REQ-002 Parameter TILE, default 16, columns processed per issue by the shared multiply/reduce engine.
REQ-003 Parameter REDUCE_LAT, default 2, cycles from issue to reduced sum valid; SHALL be >= 1.
REQ-004 Parameter COL_W, default 7, width of tile_col; SHALL hold N_IN-TILE.
REQ-005 ap_clk  in  1  single clock; all logic on rising edge.
REQ-006 ap_rst_n  in  1  synchronous, active-low reset.
REQ-007 ap_start  in  1  request one layer evaluation.
REQ-008 eng_ready  in  1  engine can accept an issue this cycle.
REQ-009 ap_ready  out  1  start accepted this cycle.
REQ-010 ap_idle  out  1  IDLE state and ap_start low.
REQ-011 ap_done  out  1  one-cycle pulse; accumulators final.
REQ-012 tile_col  out  COL_W  first column of the tile being issued.
REQ-013 issue_valid  out  1  tile at tile_col issued to engine this cycle.
REQ-014 acc_clear  out  1  load biases into accumulators at next edge.
REQ-015 acc_en  out  1  add reduced sums into accumulators at next edge.
REQ-016 result_valid  out  1  accumulator contents are a completed result.

Function
REQ-017 States SHALL be IDLE, ISSUE, DRAIN, DONE; N_TILES = N_IN/TILE.
REQ-018 IDLE: ap_start=1 -> ap_ready=1 and acc_clear=1 that cycle, result_valid cleared, tile_col=0, next state ISSUE; else stay IDLE.
REQ-019 ap_start outside IDLE SHALL be ignored: no ap_ready, no acc_clear, no effect on the sequence.
REQ-020 ISSUE: issue_valid = eng_ready; on each issue, tile_col advances by TILE at the edge; with eng_ready=0, tile_col holds and issue_valid=0.
REQ-021 ISSUE -> DRAIN at the edge ending the cycle that issues tile_col = N_IN-TILE; tile_col SHALL NOT wrap or exceed N_IN-TILE during a run.
REQ-022 acc_en SHALL equal issue_valid delayed exactly REDUCE_LAT cycles via a free-running valid shift register that eng_ready does not stall.
REQ-023 In-flight counter: +1 per issue, -1 per acc_en, simultaneous events cancel; SHALL never exceed REDUCE_LAT.
REQ-024 DRAIN -> DONE when acc_en=1 and in-flight count = 1; otherwise stay DRAIN.
REQ-025 DONE: ap_done=1 for exactly one cycle; result_valid set at the edge leaving DONE; next state IDLE.
REQ-026 result_valid SHALL stay high until the next accepted start.
REQ-027 With eng_ready held high, start acceptance to ap_done SHALL be 1+N_TILES+REDUCE_LAT cycles (7 with defaults); each stall cycle adds one.
REQ-028 N_TILES=1 SHALL go IDLE->ISSUE->DRAIN after a single issue, no special casing.
REQ-029 issue_valid, acc_en and acc_clear SHALL never be high together in the same cycle.

Reset
REQ-030 ap_rst_n=0 at an edge SHALL force IDLE, tile_col=0, in-flight=0, valid shift register cleared, result_valid=0.
REQ-031 During and after reset: ap_done, ap_ready, issue_valid, acc_en, acc_clear = 0; ap_idle = !ap_start.
REQ-032 Reset mid-run (any state) SHALL abort with no further acc_en pulses from issues made before reset.

Verification
REQ-033 Defaults, eng_ready=1, start pulse at cycle 0 -> ap_ready/acc_clear cycle 0; issue_valid cycles 1-4 with tile_col 0,16,32,48; acc_en cycles 3-6; ap_done cycle 7; result_valid high from cycle 8.
REQ-034 eng_ready=0 in cycles 2-3 of the above -> tile_col holds 16; issues at cycles 1,4,5,6; acc_en 3,6,7,8; ap_done cycle 9.
REQ-035 ap_start held high throughout -> only one ap_ready per run; runs restart the cycle after DONE; acc_clear never coincides with acc_en.
REQ-036 ap_rst_n=0 for one cycle at cycle 3 of REQ-033 -> IDLE at cycle 4, no acc_en or ap_done thereafter until a new start.
REQ-037 N_IN=16, TILE=16, REDUCE_LAT=1 -> issue cycle 1, acc_en cycle 2, ap_done cycle 3.
REQ-038 Randomised eng_ready over 1000 runs -> acc_en count = N_TILES per run, in-flight <= REDUCE_LAT, tile_col always <= N_IN-TILE.
